// File: rtl/signed_delta.sv
// signed_delta: streaming signed differencer, out = sample - previous sample of the same stream
//   Two-stage valid/ready pipeline, one sample per cycle.
//   Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_first (upstream);
//          out_valid/out_ready/out_data/out_ovf (downstream); ovf_sticky (overflow since reset/in_first).
//   Macro SIGNED_DELTA_SAT_EN: clamp overflowed deltas instead of packing them.
module signed_delta #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             ovf_sticky
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b, prev, res;
  logic [WIDTH:0]   temp;
  logic             ovf, s2_load, in_fire;
  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign in_fire  = in_valid & in_ready;
  assign temp     = {s1_a[WIDTH-1], s1_a} - {s1_b[WIDTH-1], s1_b};
  assign ovf      = temp[WIDTH] ^ temp[WIDTH-1];
  // Packing keeps the true sign and drops bit WIDTH-1, matching signed_add.
`ifdef SIGNED_DELTA_SAT_EN
  assign res = ovf ? (temp[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                   : {temp[WIDTH], temp[WIDTH-2:0]};
`else
  assign res = {temp[WIDTH], temp[WIDTH-2:0]};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      prev       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_a <= in_data;
        s1_b <= in_first ? '0 : prev;
        prev <= in_data;
      end
      if (s2_load) begin
        out_data <= res;
        out_ovf  <= ovf;
      end
      s1_valid   <= in_fire | (s1_valid & ~s2_load);
      out_valid  <= s2_load | (out_valid & ~out_ready);
      // A set on the same edge as an in_first clear wins.
      ovf_sticky <= (s2_load & ovf) | (ovf_sticky & ~(in_fire & in_first));
    end
  end
endmodule

// File: tb/tb_signed_delta.sv
// tb_signed_delta: directed and randomized checks of signed_delta against an arithmetic reference model
module tb_signed_delta;
  localparam int W = 10;
  localparam int HALF = 1 << (W - 1);
  logic clk, rst, in_valid, in_ready, in_first, out_valid, out_ready, out_ovf, ovf_sticky;
  logic [W-1:0] in_data, out_data;
  int total, bad, n_out, loaded_before, model_prev;
  bit sticky_m, saw_stall;
  int src_d[$];
  bit src_f[$];
  int exp_d[$];
  bit exp_o[$];
  bit ovf_hist[$];

  signed_delta #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input bit f);
    src_d.push_back(d);
    src_f.push_back(f);
  endtask

  // Reference delta: plain integer subtraction, then the packing or clamping rule on overflow.
  task automatic model_accept(input int d, input bit f);
    int delta, r;
    bit o;
    delta = d - (f ? 0 : model_prev);
    o = delta > HALF - 1 || delta < -HALF;
`ifdef SIGNED_DELTA_SAT_EN
    r = !o ? delta : (delta > 0 ? HALF - 1 : -HALF);
`else
    r = !o ? delta : (delta > 0 ? delta - HALF : delta + HALF);
`endif
    exp_d.push_back(r & ((1 << W) - 1));
    exp_o.push_back(o);
    ovf_hist.push_back(o);
    model_prev = d;
  endtask

  // One clock: drive at post-edge, sample handshakes at negedge, update sticky model after the edge.
  task automatic step(input bit r, input bit want);
    bit ia, oa, set;
    int loaded_now;
    if (!in_valid && want && src_d.size() > 0) begin
      in_valid = 1'b1;
      in_data = src_d[0][W-1:0];
      in_first = src_f[0];
    end
    out_ready = r;
    @(negedge clk);
    ia = in_valid & in_ready;
    oa = out_valid & out_ready;
    if (in_valid && !in_ready) saw_stall = 1'b1;
    if (oa) begin
      if (exp_d.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
      else begin
        chk("out_data", out_data, exp_d.pop_front());
        chk("out_ovf", out_ovf, exp_o.pop_front());
      end
      n_out++;
    end
    if (ia) begin
      model_accept(src_d.pop_front(), src_f.pop_front());
    end
    @(posedge clk);
    #1;
    loaded_now = n_out + int'(out_valid);
    set = 1'b0;
    for (int i = loaded_before; i < loaded_now && i < ovf_hist.size(); i++) set |= ovf_hist[i];
    loaded_before = loaded_now;
    sticky_m = set | (sticky_m & ~(ia & in_first));
    chk("ovf_sticky", ovf_sticky, sticky_m);
    if (ia) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((src_d.size() > 0 || in_valid || exp_d.size() > 0 || out_valid) && n < 40) begin
      step(1'b1, 1'b1);
      n++;
    end
    chk("drain_timeout", n < 40, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    src_d.delete(); src_f.delete(); exp_d.delete(); exp_o.delete(); ovf_hist.delete();
    n_out = 0; loaded_before = 0; sticky_m = 1'b0; model_prev = 0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_data = '0; in_first = 1'b0; out_ready = 1'b0;
    total = 0; bad = 0; saw_stall = 1'b0;
    @(posedge clk);
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    // Basic stream with latency check.
    push(100, 1); push(150, 0);
    step(1'b1, 1'b1);
    chk("lat_edge1", out_valid, 0);
    step(1'b1, 1'b1);
    chk("lat_edge2", out_valid, 1);
    drain();
    // Negative overflow.
    push(511, 1); push(-512, 0);
    drain();
    chk("neg_ovf_sticky", ovf_sticky, 1);
    // Positive overflow.
    push(-512, 1); push(511, 0);
    drain();
    chk("pos_ovf_sticky", ovf_sticky, 1);
    // Backpressure: out_ready low for cycles 2-6.
    saw_stall = 1'b0;
    push(10, 1); push(20, 0); push(30, 0); push(40, 0); push(50, 0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    chk("bp_in_ready_dropped", saw_stall, 1);
    drain();
    // Stream restart after an overflow; idle gap so the clear is not masked by a set.
    push(5, 1); push(8, 0); push(-512, 0);
    drain();
    chk("restart_pre_sticky", ovf_sticky, 1);
    push(300, 1);
    drain();
    chk("restart_sticky_clear", ovf_sticky, 0);
    // Reset with both stages full.
    push(1, 1); push(2, 0); push(3, 0); push(4, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk("full_in_ready", in_ready, 0);
    do_reset();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    push(7, 0);
    drain();
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (src_d.size() == 0 && $urandom_range(3) != 0)
        push(int'($urandom_range((1 << W) - 1)) - HALF, $urandom_range(7) == 0);
      step($urandom_range(9) < 7, $urandom_range(4) != 0);
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
